// File: rtl/pipe_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline. Decides each cycle between
// freeze, branch flush, RAW-hazard bubble or run. It also keeps a saturating
// stall-cycle counter and a sticky watchdog for hung multi-cycle stages.
module pipe_hazard_controller #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned MAX_STALL = 255,
   parameter bit          WB_BYPASS = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ex_valid_i,
   input  logic             ex_ready_i,
   input  logic             mem_valid_i,
   input  logic             mem_ready_i,
   input  logic             branch_taken_i,
   input  logic [4:0]       a1_id_i,
   input  logic [4:0]       a2_id_i,
   input  logic             use_a1_i,
   input  logic             use_a2_i,
   input  logic [4:0]       a3_ex_i,
   input  logic [4:0]       a3_mem_i,
   input  logic [4:0]       a3_wb_i,
   input  logic             we_ex_i,
   input  logic             we_mem_i,
   input  logic             we_wb_i,
   output logic             pc_en_o,
   output logic             if_id_en_o,
   output logic             id_ex_en_o,
   output logic             ex_mem_en_o,
   output logic             mem_wb_en_o,
   output logic             if_id_flush_o,
   output logic             id_ex_flush_o,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic             timeout_o
);

   typedef enum logic [2:0] {
      StRun     = 3'd0,
      StExWait  = 3'd1,
      StMemWait = 3'd2,
      StHazard  = 3'd3,
      StFlush   = 3'd4
   } state_e;

   localparam logic [CNT_W-1:0] MaxStall = CNT_W'(MAX_STALL);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             timeout_q, timeout_d;

   logic mem_frz, ex_frz, freeze;
   logic wb_chk;
   logic a1_hit, a2_hit, hazard;

   assign mem_frz = mem_valid_i & ~mem_ready_i;
   assign ex_frz  = ex_valid_i & ~ex_ready_i;
   assign freeze  = mem_frz | ex_frz;

   // WB writer only matters when the register file cannot write-before-read.
   assign wb_chk = we_wb_i & ~WB_BYPASS;

   assign a1_hit = (we_ex_i & (a1_id_i == a3_ex_i)) | (we_mem_i & (a1_id_i == a3_mem_i)) |
                   (wb_chk & (a1_id_i == a3_wb_i));
   assign a2_hit = (we_ex_i & (a2_id_i == a3_ex_i)) | (we_mem_i & (a2_id_i == a3_mem_i)) |
                   (wb_chk & (a2_id_i == a3_wb_i));
   assign hazard = (use_a1_i & a1_hit) | (use_a2_i & a2_hit);

   // Priority decision: freeze > branch > hazard > run; outputs forced low in reset.
   always_comb begin
      pc_en_o       = 1'b1;
      if_id_en_o    = 1'b1;
      id_ex_en_o    = 1'b1;
      ex_mem_en_o   = 1'b1;
      mem_wb_en_o   = 1'b1;
      if_id_flush_o = 1'b0;
      id_ex_flush_o = 1'b0;
      state_d       = StRun;
      if (freeze) begin
         pc_en_o     = 1'b0;
         if_id_en_o  = 1'b0;
         id_ex_en_o  = 1'b0;
         ex_mem_en_o = 1'b0;
         mem_wb_en_o = 1'b0;
         state_d     = mem_frz ? StMemWait : StExWait;
      end else if (branch_taken_i && (state_q != StFlush)) begin
         // In FLUSH the EX stage holds a bubble, so a branch there is stale.
         if_id_flush_o = 1'b1;
         id_ex_flush_o = 1'b1;
         state_d       = StFlush;
      end else if (hazard) begin
         pc_en_o       = 1'b0;
         if_id_en_o    = 1'b0;
         id_ex_flush_o = 1'b1;
         state_d       = StHazard;
      end
      if (RST) begin
         pc_en_o       = 1'b0;
         if_id_en_o    = 1'b0;
         id_ex_en_o    = 1'b0;
         ex_mem_en_o   = 1'b0;
         mem_wb_en_o   = 1'b0;
         if_id_flush_o = 1'b0;
         id_ex_flush_o = 1'b0;
      end
   end

   // Freeze run length, watchdog and saturating stall counter next-state.
   always_comb begin
      freeze_cnt_d = '0;
      if (freeze) begin
         freeze_cnt_d = (freeze_cnt_q == '1) ? freeze_cnt_q : freeze_cnt_q + 1'b1;
      end
      timeout_d   = timeout_q | (freeze & (freeze_cnt_d >= MaxStall));
      stall_cnt_d = stall_cnt_q;
      if (!pc_en_o && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // State and counter registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= StRun;
         freeze_cnt_q <= '0;
         stall_cnt_q  <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         freeze_cnt_q <= freeze_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
         timeout_q    <= timeout_d;
      end
   end

   assign state_o        = state_q;
   assign stall_cycles_o = stall_cnt_q;
   assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_controller.sv
// Bench for pipe_hazard_controller: two instances (WB bypass on / off, narrow
// stall counter on the second) against a rule-level model, plus directed cases.
module tb_pipe_hazard_controller;

   localparam int MAX_ST = 8;
   localparam logic [6:0] V_RUN = 7'b1111100;
   localparam logic [6:0] V_FRZ = 7'b0000000;
   localparam logic [6:0] V_HAZ = 7'b0011101;
   localparam logic [6:0] V_BR  = 7'b1111111;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic ex_valid_i = 0, ex_ready_i = 0, mem_valid_i = 0, mem_ready_i = 0;
   logic branch_taken_i = 0;
   logic [4:0] a1_id_i = 0, a2_id_i = 0, a3_ex_i = 0, a3_mem_i = 0, a3_wb_i = 0;
   logic use_a1_i = 0, use_a2_i = 0, we_ex_i = 0, we_mem_i = 0, we_wb_i = 0;

   logic pc_a, ifid_a, idex_a, exmem_a, memwb_a, iff_a, idf_a, to_a;
   logic pc_b, ifid_b, idex_b, exmem_b, memwb_b, iff_b, idf_b, to_b;
   logic [2:0]  state_a, state_b;
   logic [15:0] stall_a;
   logic [3:0]  stall_b;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   always #5 CLK = ~CLK;

   pipe_hazard_controller #(.CNT_W(16), .MAX_STALL(MAX_ST), .WB_BYPASS(1'b1)) dut_a (
      .CLK(CLK), .RST(RST), .ex_valid_i(ex_valid_i), .ex_ready_i(ex_ready_i),
      .mem_valid_i(mem_valid_i), .mem_ready_i(mem_ready_i), .branch_taken_i(branch_taken_i),
      .a1_id_i(a1_id_i), .a2_id_i(a2_id_i), .use_a1_i(use_a1_i), .use_a2_i(use_a2_i),
      .a3_ex_i(a3_ex_i), .a3_mem_i(a3_mem_i), .a3_wb_i(a3_wb_i),
      .we_ex_i(we_ex_i), .we_mem_i(we_mem_i), .we_wb_i(we_wb_i),
      .pc_en_o(pc_a), .if_id_en_o(ifid_a), .id_ex_en_o(idex_a), .ex_mem_en_o(exmem_a),
      .mem_wb_en_o(memwb_a), .if_id_flush_o(iff_a), .id_ex_flush_o(idf_a),
      .state_o(state_a), .stall_cycles_o(stall_a), .timeout_o(to_a)
   );

   pipe_hazard_controller #(.CNT_W(4), .MAX_STALL(MAX_ST), .WB_BYPASS(1'b0)) dut_b (
      .CLK(CLK), .RST(RST), .ex_valid_i(ex_valid_i), .ex_ready_i(ex_ready_i),
      .mem_valid_i(mem_valid_i), .mem_ready_i(mem_ready_i), .branch_taken_i(branch_taken_i),
      .a1_id_i(a1_id_i), .a2_id_i(a2_id_i), .use_a1_i(use_a1_i), .use_a2_i(use_a2_i),
      .a3_ex_i(a3_ex_i), .a3_mem_i(a3_mem_i), .a3_wb_i(a3_wb_i),
      .we_ex_i(we_ex_i), .we_mem_i(we_mem_i), .we_wb_i(we_wb_i),
      .pc_en_o(pc_b), .if_id_en_o(ifid_b), .id_ex_en_o(idex_b), .ex_mem_en_o(exmem_b),
      .mem_wb_en_o(memwb_b), .if_id_flush_o(iff_b), .id_ex_flush_o(idf_b),
      .state_o(state_b), .stall_cycles_o(stall_b), .timeout_o(to_b)
   );

   int vec_v[2], st_v[2], stall_v[2], to_v[2];
   assign vec_v[0]   = int'({pc_a, ifid_a, idex_a, exmem_a, memwb_a, iff_a, idf_a});
   assign vec_v[1]   = int'({pc_b, ifid_b, idex_b, exmem_b, memwb_b, iff_b, idf_b});
   assign st_v[0]    = int'(state_a);
   assign st_v[1]    = int'(state_b);
   assign stall_v[0] = int'(stall_a);
   assign stall_v[1] = int'(stall_b);
   assign to_v[0]    = int'(to_a);
   assign to_v[1]    = int'(to_b);

   // ---------------- behavioural model ----------------
   // Decision codes double as next-state codes: 0 run, 1 ex freeze, 2 mem freeze,
   // 3 hazard, 4 branch (-> FLUSH).
   function automatic bit raw_hazard(input bit bypass);
      logic [4:0] src[2];
      bit         rd[2];
      logic [4:0] dst[3];
      bit         wr[3];
      bit         hit;
      src = '{a1_id_i, a2_id_i};
      rd  = '{use_a1_i, use_a2_i};
      dst = '{a3_ex_i, a3_mem_i, a3_wb_i};
      wr  = '{we_ex_i, we_mem_i, we_wb_i && !bypass};
      hit = 0;
      for (int s = 0; s < 2; s++)
         for (int w = 0; w < 3; w++)
            if (rd[s] && wr[w] && src[s] == dst[w]) hit = 1;
      return hit;
   endfunction

   function automatic int decide(input bit bypass, input int st);
      if (mem_valid_i && !mem_ready_i) return 2;
      if (ex_valid_i && !ex_ready_i) return 1;
      if (branch_taken_i && st != 4) return 4;
      if (raw_hazard(bypass)) return 3;
      return 0;
   endfunction

   function automatic int exp_vec(input int code, input bit in_rst);
      if (in_rst) return 0;
      case (code)
         1, 2:    return int'(V_FRZ);
         3:       return int'(V_HAZ);
         4:       return int'(V_BR);
         default: return int'(V_RUN);
      endcase
   endfunction

   function automatic bit inst_bypass(input int i);
      return (i == 0);
   endfunction

   function automatic int inst_sat(input int i);
      return (i == 0) ? 65535 : 15;
   endfunction

   int m_state[2] = '{0, 0};
   int m_stall[2] = '{0, 0};
   int m_frz[2]   = '{0, 0};
   int m_to[2]    = '{0, 0};

   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 2; i++) begin
            m_state[i] <= 0;
            m_stall[i] <= 0;
            m_frz[i]   <= 0;
            m_to[i]    <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_state[i] <= decide(inst_bypass(i), m_state[i]);
            if (decide(inst_bypass(i), m_state[i]) inside {1, 2, 3} && m_stall[i] < inst_sat(i))
               m_stall[i] <= m_stall[i] + 1;
            if (decide(inst_bypass(i), m_state[i]) inside {1, 2}) begin
               m_frz[i] <= m_frz[i] + 1;
               if (m_frz[i] + 1 >= MAX_ST) m_to[i] <= 1;
            end else begin
               m_frz[i] <= 0;
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act,
                  exp, exp);
      end
   endtask

   // Compare both instances against the model every cycle, mid-cycle.
   always @(negedge CLK) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         check($sformatf("model inst%0d enables", i), vec_v[i],
               exp_vec(decide(inst_bypass(i), m_state[i]), RST));
         check($sformatf("model inst%0d state", i), st_v[i], m_state[i]);
         check($sformatf("model inst%0d stall_cycles", i), stall_v[i], m_stall[i]);
         check($sformatf("model inst%0d timeout", i), to_v[i], m_to[i]);
      end
   end

   // ---------------- directed + random stimulus ----------------
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      ex_valid_i = 0; ex_ready_i = 0; mem_valid_i = 0; mem_ready_i = 0; branch_taken_i = 0;
      a1_id_i = 0; a2_id_i = 0; a3_ex_i = 0; a3_mem_i = 0; a3_wb_i = 0;
      use_a1_i = 0; use_a2_i = 0; we_ex_i = 0; we_mem_i = 0; we_wb_i = 0;
   endtask

   initial begin
      #1;
      check("reset enables", vec_v[0], 0);
      check("reset timeout", to_v[0], 0);
      step();
      step();
      RST = 0;

      // Idle
      step(); step(); #4;
      check("idle enables", vec_v[0], int'(V_RUN));
      check("idle state", st_v[0], 0);
      check("idle stall", stall_v[0], 0);

      // Vector op: 5 cycles valid, ready in the 5th
      step(); ex_valid_i = 1; ex_ready_i = 0; #4;
      check("vec c1 enables", vec_v[0], int'(V_FRZ));
      step(); #4;
      check("vec c2 state", st_v[0], 1);
      step(); step();
      step(); ex_ready_i = 1; #4;
      check("vec c5 enables", vec_v[0], int'(V_RUN));
      step(); clear_inputs(); #4;
      check("vec stall count", stall_v[0], 4);
      check("vec back to run", st_v[0], 0);

      // Simultaneous MEM freeze and branch
      step(); mem_valid_i = 1; branch_taken_i = 1; #4;
      check("frz+br enables", vec_v[0], int'(V_FRZ));
      step(); clear_inputs(); #4;
      check("frz+br state", st_v[0], 2);

      // Branch held two cycles
      step(); branch_taken_i = 1; #4;
      check("branch c1 vec", vec_v[0], int'(V_BR));
      step(); #4;
      check("branch c2 state", st_v[0], 4);
      check("branch c2 vec", vec_v[0], int'(V_RUN));
      step(); branch_taken_i = 0; #4;
      check("after flush state", st_v[0], 0);

      // RAW hazard: producer walks EX -> MEM -> WB
      step(); a1_id_i = 5; use_a1_i = 1; a3_ex_i = 5; we_ex_i = 1; #4;
      check("raw ex inst0", vec_v[0], int'(V_HAZ));
      check("raw ex inst1", vec_v[1], int'(V_HAZ));
      step(); we_ex_i = 0; a3_ex_i = 0; a3_mem_i = 5; we_mem_i = 1; #4;
      check("raw mem inst0", vec_v[0], int'(V_HAZ));
      check("raw mem state", st_v[0], 3);
      step(); we_mem_i = 0; a3_mem_i = 0; a3_wb_i = 5; we_wb_i = 1; #4;
      check("raw wb bypass", vec_v[0], int'(V_RUN));
      check("raw wb no bypass", vec_v[1], int'(V_HAZ));
      step(); clear_inputs(); #4;
      check("raw done inst1", vec_v[1], int'(V_RUN));

      // r0 is an ordinary register
      step(); a2_id_i = 0; use_a2_i = 1; a3_mem_i = 0; we_mem_i = 1; #4;
      check("raw r0", vec_v[0], int'(V_HAZ));
      step(); clear_inputs();

      // Watchdog
      step(); ex_valid_i = 1; ex_ready_i = 0;
      for (int i = 1; i <= 10; i++) begin
         if (i > 1) step();
         #4;
         check($sformatf("watchdog c%0d timeout", i), to_v[0], (i >= 9) ? 1 : 0);
      end
      step(); ex_ready_i = 1; #4;
      check("watchdog ready vec", vec_v[0], int'(V_RUN));
      step(); clear_inputs(); #4;
      check("watchdog sticky", to_v[0], 1);

      // Async reset mid-freeze
      step(); ex_valid_i = 1;
      check("stall saturate inst1", stall_v[1], 15);
      #1 RST = 1;
      #1;
      check("async rst enables", vec_v[0], 0);
      check("async rst timeout", to_v[0], 0);
      check("async rst stall", stall_v[0], 0);
      step(); RST = 0; clear_inputs();

      // Random phase
      for (int n = 0; n < 3000; n++) begin
         step();
         if (RST) RST = 0;
         ex_valid_i     = ($urandom_range(0, 3) == 0);
         ex_ready_i     = $urandom_range(0, 1);
         mem_valid_i    = ($urandom_range(0, 3) == 0);
         mem_ready_i    = $urandom_range(0, 1);
         branch_taken_i = ($urandom_range(0, 5) == 0);
         a1_id_i  = 5'($urandom_range(0, 3));
         a2_id_i  = 5'($urandom_range(0, 3));
         a3_ex_i  = 5'($urandom_range(0, 3));
         a3_mem_i = 5'($urandom_range(0, 3));
         a3_wb_i  = 5'($urandom_range(0, 3));
         use_a1_i = $urandom_range(0, 1);
         use_a2_i = $urandom_range(0, 1);
         we_ex_i  = ($urandom_range(0, 2) == 0);
         we_mem_i = ($urandom_range(0, 2) == 0);
         we_wb_i  = ($urandom_range(0, 2) == 0);
         // Long freezes now and then so the watchdog fires in the random run too.
         if (n % 500 > 480) begin
            ex_valid_i = 1;
            ex_ready_i = 0;
         end
         if ($urandom_range(0, 199) == 0) begin
            #2 RST = 1;
         end
      end
      step(); RST = 0; clear_inputs();
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
